// File: rtl/fir8_seq.sv
// Frame sequencer for the free-running fir8 datapath: prime, stream, zero tail, drain.
// Latency: a sample on fir_xin in cycle t yields out_valid/out_data in cycle t+LATENCY+1.
// Backpressure: none; RUN never stalls, a missing input sample becomes zero and sets underrun.
module fir8_seq #(
  parameter int TAPS    = 8,
  parameter int LATENCY = 16,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             underrun,
  output logic [7:0]       fir_xin,
  output logic [15:0]      fir_yin,
  input  logic [15:0]      fir_yout,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_last
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, TAIL, DRAIN} state_t;

  localparam logic [LEN_W-1:0] PRIME_END = LEN_W'(LATENCY - 1);
  localparam logic [LEN_W-1:0] TAIL_END  = LEN_W'(TAPS - 2);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   cnt, cnt_nx;
  logic [LEN_W-1:0]   len_q;
  logic               issue_vld, issue_last;
  logic               xin_vld, xin_last;
  logic [LATENCY-1:0] pipe_vld, pipe_last;
  logic               start_ok;

  // A start is only honoured from IDLE; in the done cycle the FSM is still in DRAIN.
  assign start_ok = (state == IDLE) && start;
  assign busy     = (state != IDLE);
  assign in_ready = (state == RUN);
  assign fir_yin  = 16'd0;

  // Next-state, phase counter and tag issue for each frame phase.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    issue_vld  = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_nx = PRIME;
          cnt_nx   = '0;
        end
      end
      PRIME: begin
        if (cnt == PRIME_END) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + LEN_W'(1);
        end
      end
      RUN: begin
        issue_vld = 1'b1;
        if (cnt == len_q - LEN_W'(1)) begin
          state_nx = TAIL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + LEN_W'(1);
        end
      end
      TAIL: begin
        issue_vld = 1'b1;
        if (cnt == TAIL_END) begin
          issue_last = 1'b1;
          state_nx   = DRAIN;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + LEN_W'(1);
        end
      end
      DRAIN: begin
        // Leave one cycle after done so a start in the done cycle is ignored.
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Frame length latch, sticky underrun flag and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= '0;
      underrun <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (start_ok) len_q <= frame_len;
      if (start_ok)                         underrun <= 1'b0;
      else if ((state == RUN) && !in_valid) underrun <= 1'b1;
      done <= (start_ok && (frame_len == '0)) ||
              ((state == DRAIN) && pipe_last[LATENCY-1]);
    end
  end

  // Registered datapath drive; the tag of the sample on fir_xin travels alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fir_xin  <= 8'd0;
      xin_vld  <= 1'b0;
      xin_last <= 1'b0;
    end else begin
      fir_xin  <= ((state == RUN) && in_valid) ? in_data : 8'd0;
      xin_vld  <= issue_vld;
      xin_last <= issue_last;
    end
  end

  // Tag pipe covering the datapath latency so tags line up with fir_yout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= xin_vld;
      pipe_last[0] <= xin_last;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  // Output register; out_data only updates on valid results and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 16'd0;
    end else begin
      out_valid <= pipe_vld[LATENCY-1];
      out_last  <= pipe_last[LATENCY-1];
      if (pipe_vld[LATENCY-1]) out_data <= fir_yout;
    end
  end

endmodule
